peripheral_uart_wb_stream_bridge: RTL and testbench

Wishbone classic master that sits directly upstream of `peripheral_uart_wb` and turns its 16550 register map into two byte streams (TX in, RX out).
- After reset it programs the baud divisor, line format and FIFO control.
- It then continuously polls LSR, pushes TX bytes into THR and pops RX bytes from RBR.
- Lets a core, DMA or debug unit use the UART without any register-level software.

---
 rtl/peripheral_uart_wb_stream_bridge_pkg.sv | 31 +++
 rtl/peripheral_uart_wb_stream_bridge_if.sv | 21 ++
 rtl/peripheral_uart_wb_stream_bridge_master_port.sv | 81 ++++++++
 rtl/peripheral_uart_wb_stream_bridge.sv | 150 +++++++++++++++
 tb/tb_peripheral_uart_wb_stream_bridge.sv | 355 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/peripheral_uart_wb_stream_bridge_pkg.sv
// Shared constants and FSM state type for the UART Wishbone stream bridge.
package peripheral_uart_bridge_pkg;

  // 16550 register addresses (DLL/DLM only reachable with DLAB set)
  localparam logic [2:0] ADDR_RBR = 3'd0;
  localparam logic [2:0] ADDR_THR = 3'd0;
  localparam logic [2:0] ADDR_DLL = 3'd0;
  localparam logic [2:0] ADDR_DLM = 3'd1;
  localparam logic [2:0] ADDR_FCR = 3'd2;
  localparam logic [2:0] ADDR_LCR = 3'd3;
  localparam logic [2:0] ADDR_LSR = 3'd5;

  localparam logic [7:0] LCR_DLAB = 8'h80;
  // Enable FIFOs and clear both of them
  localparam logic [7:0] FCR_INIT = 8'h07;

  localparam int unsigned LSR_DR   = 0;
  localparam int unsigned LSR_THRE = 5;

  typedef enum logic [2:0] {
    StInitLcrDl,
    StInitDll,
    StInitDlm,
    StInitLcr,
    StInitFcr,
    StPollLsr,
    StReadRbr,
    StWriteThr
  } bridge_state_e;

endpackage

// File: rtl/peripheral_uart_wb_stream_bridge_if.sv
// Wishbone classic bus between the bridge (master) and the UART (slave).
interface peripheral_uart_wb_stream_bridge_if;
  logic [2:0] wb_adr_o;
  logic [7:0] wb_dat_o;
  logic [7:0] wb_dat_i;
  logic       wb_we_o;
  logic       wb_stb_o;
  logic       wb_cyc_o;
  logic [3:0] wb_sel_o;
  logic       wb_ack_i;

  modport master (
    output wb_adr_o, wb_dat_o, wb_we_o, wb_stb_o, wb_cyc_o, wb_sel_o,
    input  wb_dat_i, wb_ack_i
  );

  modport slave (
    input  wb_adr_o, wb_dat_o, wb_we_o, wb_stb_o, wb_cyc_o, wb_sel_o,
    output wb_dat_i, wb_ack_i
  );
endinterface

// File: rtl/peripheral_uart_wb_stream_bridge_master_port.sv
// Single Wishbone classic access engine. A start pulse launches one access
// (only while the bus is idle, which enforces the idle gap); done/rdat report
// completion in the ack cycle. Optional ack watchdog: UART_BRIDGE_TIMEOUT_EN.
module peripheral_uart_wb_master_port #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic       start,
  input  logic       we,
  input  logic [2:0] adr,
  input  logic [7:0] wdat,
  output logic       done,
  output logic [7:0] rdat,
  output logic       err,
  peripheral_uart_wb_stream_bridge_if.master wb
);

  logic       cyc_q;
  logic       we_q;
  logic [2:0] adr_q;
  logic [7:0] dat_q;
  logic       acked;

  assign acked = cyc_q && wb.wb_ack_i;

`ifdef UART_BRIDGE_TIMEOUT_EN
  logic [15:0] cnt_q;
  logic        err_q;
  logic        expire;

  assign expire = cyc_q && !wb.wb_ack_i && (cnt_q == 16'(TIMEOUT - 1));
  assign done   = acked || expire;
  // Abandoned reads return zero
  assign rdat   = acked ? wb.wb_dat_i : 8'h00;
  assign err    = err_q;

  // Watchdog counts cycles of the current access; error flag is sticky
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= (cyc_q && !done) ? cnt_q + 16'd1 : '0;
      if (expire) err_q <= 1'b1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign done = acked;
  assign rdat = wb.wb_dat_i;
  assign err  = 1'b0;
`endif

  // Bus signals are captured at start and held until the access completes
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      cyc_q <= 1'b0;
      we_q  <= 1'b0;
      adr_q <= '0;
      dat_q <= '0;
    end else if (done) begin
      cyc_q <= 1'b0;
      we_q  <= 1'b0;
    end else if (start && !cyc_q) begin
      cyc_q <= 1'b1;
      we_q  <= we;
      adr_q <= adr;
      dat_q <= wdat;
    end
  end

  assign wb.wb_cyc_o = cyc_q;
  assign wb.wb_stb_o = cyc_q;
  assign wb.wb_we_o  = we_q;
  assign wb.wb_adr_o = adr_q;
  assign wb.wb_dat_o = dat_q;
  assign wb.wb_sel_o = 4'b0001;

endmodule

// File: rtl/peripheral_uart_wb_stream_bridge.sv
// Wishbone master that initialises a 16550 UART and then exposes it as a TX
// byte stream in and an RX byte stream out by polling LSR.
// Optional ack watchdog: define UART_BRIDGE_TIMEOUT_EN.
module peripheral_uart_wb_stream_bridge
  import peripheral_uart_bridge_pkg::*;
#(
  parameter logic [15:0] DIVISOR = 16'd27,
  parameter logic [7:0]  LCR_FMT = 8'h03,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  peripheral_uart_wb_stream_bridge_if.master wb,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  output logic       init_done_o,
  output logic       err_o
);

  bridge_state_e state_q;
  logic          start_q;
  logic          busy_q;
  logic          last_rx_q;
  logic          tx_ready_q;
  logic          init_done_q;
  logic [7:0]    rx_data_q;
  logic          rx_valid_q;

  logic          done;
  logic [7:0]    rdat;
  logic          acc_we;
  logic [2:0]    acc_adr;
  logic [7:0]    acc_wdat;
  logic          rx_elig;
  logic          tx_elig;
  logic          pick_rx;
  logic          pick_tx;

  peripheral_uart_wb_master_port #(
    .TIMEOUT(TIMEOUT)
  ) u_port (
    .wb_clk_i(wb_clk_i),
    .wb_rst_i(wb_rst_i),
    .start   (start_q),
    .we      (acc_we),
    .adr     (acc_adr),
    .wdat    (acc_wdat),
    .done    (done),
    .rdat    (rdat),
    .err     (err_o),
    .wb      (wb)
  );

  // Access fields for the current state; sampled by the port on start
  always_comb begin
    acc_we   = 1'b1;
    acc_adr  = ADDR_LCR;
    acc_wdat = 8'h00;
    unique case (state_q)
      StInitLcrDl: begin acc_adr = ADDR_LCR; acc_wdat = LCR_DLAB | LCR_FMT; end
      StInitDll:   begin acc_adr = ADDR_DLL; acc_wdat = DIVISOR[7:0];       end
      StInitDlm:   begin acc_adr = ADDR_DLM; acc_wdat = DIVISOR[15:8];      end
      StInitLcr:   begin acc_adr = ADDR_LCR; acc_wdat = LCR_FMT;            end
      StInitFcr:   begin acc_adr = ADDR_FCR; acc_wdat = FCR_INIT;           end
      StPollLsr:   begin acc_we = 1'b0; acc_adr = ADDR_LSR;                 end
      StReadRbr:   begin acc_we = 1'b0; acc_adr = ADDR_RBR;                 end
      StWriteThr:  begin acc_adr = ADDR_THR; acc_wdat = tx_data_i;          end
      default: ;
    endcase
  end

  // Arbitration on fresh LSR data: alternate when both directions are ready
  always_comb begin
    rx_elig = rdat[LSR_DR] && !rx_valid_q;
    tx_elig = rdat[LSR_THRE] && tx_valid_i;
    pick_rx = rx_elig && (!tx_elig || !last_rx_q);
    pick_tx = tx_elig && !pick_rx;
  end

  // Sequencer: one access per state, next access requested in the ack cycle
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= StInitLcrDl;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
      last_rx_q   <= 1'b0;
      tx_ready_q  <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      start_q    <= 1'b0;
      tx_ready_q <= 1'b0;
      if (!busy_q) begin
        start_q <= 1'b1;
        busy_q  <= 1'b1;
      end else if (done) begin
        start_q <= 1'b1;
        unique case (state_q)
          StInitLcrDl: state_q <= StInitDll;
          StInitDll:   state_q <= StInitDlm;
          StInitDlm:   state_q <= StInitLcr;
          StInitLcr:   state_q <= StInitFcr;
          StInitFcr: begin
            state_q     <= StPollLsr;
            init_done_q <= 1'b1;
          end
          StPollLsr: begin
            if (pick_rx) begin
              state_q   <= StReadRbr;
              last_rx_q <= 1'b1;
            end else if (pick_tx) begin
              state_q   <= StWriteThr;
              last_rx_q <= 1'b0;
            end else begin
              state_q <= StPollLsr;
            end
          end
          StReadRbr:  state_q <= StPollLsr;
          StWriteThr: begin
            state_q    <= StPollLsr;
            tx_ready_q <= 1'b1;
          end
          default: state_q <= StInitLcrDl;
        endcase
      end
    end
  end

  // Single-entry RX holding register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else if (done && state_q == StReadRbr) begin
      rx_data_q  <= rdat;
      rx_valid_q <= 1'b1;
    end else if (rx_valid_q && rx_ready_i) begin
      rx_valid_q <= 1'b0;
    end
  end

  assign tx_ready_o  = tx_ready_q;
  assign rx_data_o   = rx_data_q;
  assign rx_valid_o  = rx_valid_q;
  assign init_done_o = init_done_q;

endmodule

// File: tb/tb_peripheral_uart_wb_stream_bridge.sv
// Directed bench for the UART Wishbone stream bridge with a simple 16550 slave
// model (configurable wait states, optional never-ack).
module tb_peripheral_uart_wb_stream_bridge;

  typedef struct packed {
    logic [2:0] adr;
    logic       we;
    logic [7:0] dat;
  } acc_t;

  typedef struct {
    string      name;
    logic [2:0] adr;
    logic       we;
    logic [7:0] dat;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic       init_done;
  logic       err;

  peripheral_uart_wb_stream_bridge_if bus ();

  peripheral_uart_wb_stream_bridge #(
    .DIVISOR(16'h0102),
    .LCR_FMT(8'h03),
    .TIMEOUT(16)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .wb         (bus),
    .tx_data_i  (tx_data),
    .tx_valid_i (tx_valid),
    .tx_ready_o (tx_ready),
    .rx_data_o  (rx_data),
    .rx_valid_o (rx_valid),
    .rx_ready_i (rx_ready),
    .init_done_o(init_done),
    .err_o      (err)
  );

  // Slave model
  int unsigned waits = 0;
  int unsigned wcnt = 0;
  bit          no_ack = 1'b0;
  logic [7:0]  lsr_val = 8'h00;
  logic [7:0]  rbr_val = 8'h00;

  assign bus.wb_ack_i = bus.wb_cyc_o && bus.wb_stb_o && !no_ack && (wcnt == waits);
  assign bus.wb_dat_i = (bus.wb_adr_o == 3'd5) ? lsr_val :
                        (bus.wb_adr_o == 3'd0) ? rbr_val : 8'h00;

  always @(posedge clk) wcnt <= (bus.wb_cyc_o && !bus.wb_ack_i) ? wcnt + 1 : 0;

  // Completed-access log and protocol monitors
  acc_t log_q[$];
  acc_t prev_acc;
  acc_t cur_acc;
  logic prev_cyc = 1'b0;
  logic prev_ack = 1'b0;
  int   hold_err = 0;
  int   gap_err = 0;
  int   tx_ready_cnt = 0;

  assign cur_acc = '{adr: bus.wb_adr_o, we: bus.wb_we_o, dat: bus.wb_dat_o};

  always @(posedge clk) begin
    if (!rst && bus.wb_cyc_o && bus.wb_ack_i) log_q.push_back(cur_acc);
    if (!rst && prev_cyc && !prev_ack && bus.wb_cyc_o && cur_acc != prev_acc)
      hold_err <= hold_err + 1;
    if (!rst && prev_cyc && prev_ack && bus.wb_cyc_o) gap_err <= gap_err + 1;
    if (tx_ready) tx_ready_cnt <= tx_ready_cnt + 1;
    prev_cyc <= bus.wb_cyc_o;
    prev_ack <= bus.wb_ack_i;
    prev_acc <= cur_acc;
  end

  int n_tests = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_log(input int n, input int budget, input string name);
    int k = 0;
    while (log_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    check(name, 32'(log_q.size() >= n), 32'd1);
  endtask

  task automatic check_acc(input string name, input acc_t a, input vec_t v);
    check({name, "_adr"}, 32'(a.adr), 32'(v.adr));
    check({name, "_we"}, 32'(a.we), 32'(v.we));
    if (v.we) check({name, "_dat"}, 32'(a.dat), 32'(v.dat));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  vec_t init_v[5];
  vec_t alt_v[8];

  initial begin
    int n;
    int k;
    int base;
    int txb;
    int w;
    int rbr_reads;
    int lsr_reads;

    init_v[0] = '{"init_lcr_dlab", 3'd3, 1'b1, 8'h83};
    init_v[1] = '{"init_dll",      3'd0, 1'b1, 8'h02};
    init_v[2] = '{"init_dlm",      3'd1, 1'b1, 8'h01};
    init_v[3] = '{"init_lcr",      3'd3, 1'b1, 8'h03};
    init_v[4] = '{"init_fcr",      3'd2, 1'b1, 8'h07};

    alt_v[0] = '{"alt0_lsr", 3'd5, 1'b0, 8'h00};
    alt_v[1] = '{"alt1_rbr", 3'd0, 1'b0, 8'h00};
    alt_v[2] = '{"alt2_lsr", 3'd5, 1'b0, 8'h00};
    alt_v[3] = '{"alt3_thr", 3'd0, 1'b1, 8'h10};
    alt_v[4] = '{"alt4_lsr", 3'd5, 1'b0, 8'h00};
    alt_v[5] = '{"alt5_rbr", 3'd0, 1'b0, 8'h00};
    alt_v[6] = '{"alt6_lsr", 3'd5, 1'b0, 8'h00};
    alt_v[7] = '{"alt7_thr", 3'd0, 1'b1, 8'h11};

    // Reset values
    rst = 1'b1;
    repeat (3) tick();
    check("rst_cyc", 32'(bus.wb_cyc_o), 0);
    check("rst_stb", 32'(bus.wb_stb_o), 0);
    check("rst_we", 32'(bus.wb_we_o), 0);
    check("rst_adr", 32'(bus.wb_adr_o), 0);
    check("rst_dat", 32'(bus.wb_dat_o), 0);
    check("rst_sel", 32'(bus.wb_sel_o), 32'h1);
    check("rst_tx_ready", 32'(tx_ready), 0);
    check("rst_rx_valid", 32'(rx_valid), 0);
    check("rst_rx_data", 32'(rx_data), 0);
    check("rst_init_done", 32'(init_done), 0);
    check("rst_err", 32'(err), 0);

    // Init sequence, zero-wait slave
    log_q.delete();
    rst = 1'b0;
    tick();
    check("cyc_edge1", 32'(bus.wb_cyc_o), 0);
    tick();
    check("cyc_edge2", 32'(bus.wb_cyc_o), 1);
    check("init_done_early", 32'(init_done), 0);
    n = 2;
    while (log_q.size() < 5 && n < 100) begin
      tick();
      n++;
    end
    check("init_edges", 32'(n), 32'd11);
    check("init_done", 32'(init_done), 1);
    for (int i = 0; i < 5; i++) check_acc(init_v[i].name, log_q[i], init_v[i]);

    // TX path
    base = log_q.size();
    txb = tx_ready_cnt;
    lsr_val = 8'h20;
    tx_data = 8'h55;
    tx_valid = 1'b1;
    k = 0;
    while (!tx_ready && k < 100) begin
      tick();
      k++;
    end
    check("tx_ready_seen", 32'(tx_ready), 1);
    tx_valid = 1'b0;
    lsr_val = 8'h00;
    tick();
    check("tx_ready_pulse_end", 32'(tx_ready), 0);
    repeat (10) tick();
    check("tx_ready_count", 32'(tx_ready_cnt - txb), 1);
    w = -1;
    n = 0;
    for (int i = base; i < log_q.size(); i++) begin
      if (log_q[i].we) begin
        n++;
        if (w < 0) w = i;
      end
    end
    check("thr_write_count", 32'(n), 1);
    if (w > base) begin
      check("thr_adr", 32'(log_q[w].adr), 0);
      check("thr_dat", 32'(log_q[w].dat), 32'h55);
      check("thr_after_lsr", 32'({log_q[w-1].adr, log_q[w-1].we}), 32'({3'd5, 1'b0}));
    end else begin
      check("thr_found", 32'(w > base), 1);
    end

    // RX path with consumer stalled
    lsr_val = 8'h01;
    rbr_val = 8'hA5;
    rx_ready = 1'b0;
    k = 0;
    while (!rx_valid && k < 100) begin
      tick();
      k++;
    end
    check("rx_valid_seen", 32'(rx_valid), 1);
    check("rx_data", 32'(rx_data), 32'hA5);
    base = log_q.size();
    rbr_val = 8'h5A;
    repeat (30) tick();
    rbr_reads = 0;
    lsr_reads = 0;
    for (int i = base; i < log_q.size(); i++) begin
      if (!log_q[i].we && log_q[i].adr == 3'd0) rbr_reads++;
      if (!log_q[i].we && log_q[i].adr == 3'd5) lsr_reads++;
    end
    check("rx_no_extra_rbr", 32'(rbr_reads), 0);
    check("rx_polling_continues", 32'(lsr_reads > 3), 1);
    check("rx_held_valid", 32'(rx_valid), 1);
    check("rx_held_data", 32'(rx_data), 32'hA5);
    lsr_val = 8'h00;
    rx_ready = 1'b1;
    tick();
    check("rx_valid_cleared", 32'(rx_valid), 0);
    rx_ready = 1'b0;

    // Alternation after a fresh reset: RX first
    rst = 1'b1;
    lsr_val = 8'h21;
    rbr_val = 8'h3C;
    tx_valid = 1'b1;
    tx_data = 8'h10;
    rx_ready = 1'b1;
    repeat (2) tick();
    log_q.delete();
    rst = 1'b0;
    k = 0;
    while (log_q.size() < 13 && k < 200) begin
      tick();
      if (tx_ready) tx_data = tx_data + 8'h01;
      k++;
    end
    check("alt_log_len", 32'(log_q.size() >= 13), 1);
    tx_valid = 1'b0;
    lsr_val = 8'h00;
    if (log_q.size() >= 13)
      for (int i = 0; i < 8; i++) check_acc(alt_v[i].name, log_q[5 + i], alt_v[i]);
    rx_ready = 1'b0;

    // Wait states, then reset in the middle of a THR write with an RX byte held
    rst = 1'b1;
    waits = 3;
    repeat (2) tick();
    log_q.delete();
    rst = 1'b0;
    wait_log(5, 200, "ws_init_complete");
    check("ws_init_done", 32'(init_done), 1);
    check_acc("ws_first", log_q[0], init_v[0]);
    check_acc("ws_fifth", log_q[4], init_v[4]);
    lsr_val = 8'h01;
    rbr_val = 8'hC3;
    k = 0;
    while (!rx_valid && k < 200) begin
      tick();
      k++;
    end
    check("ws_rx_valid", 32'(rx_valid), 1);
    check("ws_rx_data", 32'(rx_data), 32'hC3);
    lsr_val = 8'h20;
    tx_valid = 1'b1;
    tx_data = 8'hAA;
    txb = tx_ready_cnt;
    k = 0;
    while (!(bus.wb_cyc_o && bus.wb_we_o && bus.wb_adr_o == 3'd0) && k < 200) begin
      tick();
      k++;
    end
    check("ws_thr_started", 32'(bus.wb_cyc_o && bus.wb_we_o), 1);
    tick();
    rst = 1'b1;
    tick();
    check("mid_rst_cyc", 32'(bus.wb_cyc_o), 0);
    check("mid_rst_stb", 32'(bus.wb_stb_o), 0);
    check("mid_rst_rx_valid", 32'(rx_valid), 0);
    check("mid_rst_rx_data", 32'(rx_data), 0);
    check("mid_rst_init_done", 32'(init_done), 0);
    rst = 1'b0;
    tx_valid = 1'b0;
    lsr_val = 8'h00;
    base = log_q.size();
    wait_log(base + 1, 100, "restart_access");
    if (log_q.size() > base) check_acc("restart_first", log_q[base], init_v[0]);
    check("mid_rst_no_tx_ready", 32'(tx_ready_cnt - txb), 0);
    check("hold_stable", 32'(hold_err), 0);
    check("idle_gap", 32'(gap_err), 0);

`ifdef UART_BRIDGE_TIMEOUT_EN
    // Slave never acks: access abandoned after TIMEOUT cycles
    rst = 1'b1;
    waits = 0;
    no_ack = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    k = 0;
    while (!bus.wb_cyc_o && k < 10) begin
      tick();
      k++;
    end
    n = 0;
    while (bus.wb_cyc_o && n < 100) begin
      n++;
      tick();
    end
    check("to_cyc_cycles", 32'(n), 32'd16);
    check("to_err", 32'(err), 1);
    k = 0;
    while (!bus.wb_cyc_o && k < 10) begin
      tick();
      k++;
    end
    check("to_next_adr", 32'(bus.wb_adr_o), 0);
    check("to_next_dat", 32'(bus.wb_dat_o), 32'h02);
    no_ack = 1'b0;
    repeat (40) tick();
    check("to_err_sticky", 32'(err), 1);
`else
    check("no_timeout_err", 32'(err), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
